// File: rtl/jug_fltcfm_if.sv
// Bus bundle for jug_fltcfm: comparator sample inputs, channel control and
// the fault-confirmation status outputs.
// master: the side that drives samples/control (comparator + control regs).
// slave : the fault-confirmation block.
interface jug_fltcfm_if #(
    parameter int EVT_W = 16
);
    logic             chn_en;
    logic             jug_vld;
    logic             jug_result;
    logic             flt_clr;
    logic             flt_flag;
    logic             flt_pulse;
    logic [EVT_W-1:0] flt_cnt;
    logic [1:0]       flt_sta;

    modport master (
        output chn_en, jug_vld, jug_result, flt_clr,
        input  flt_flag, flt_pulse, flt_cnt, flt_sta
    );

    modport slave (
        input  chn_en, jug_vld, jug_result, flt_clr,
        output flt_flag, flt_pulse, flt_cnt, flt_sta
    );
endinterface

// File: rtl/jug_fltcfm.sv
// Fault confirmation for one AI channel: debounces the per-sample over-limit
// result into a confirmed fault flag with separate confirm/recover run lengths,
// and counts confirmations in a saturating event counter.
// Build option FLT_LATCH_EN: a confirmed fault stays latched until flt_clr is
// given together with a valid in-limit sample (RECOVER is then unreachable).
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_NORMAL  | no fault, last valid sample in limit
// ST_SUSPECT | run of over-limit samples in progress, not yet confirmed
// ST_FAULT   | fault confirmed, flt_flag high
// ST_RECOVER | run of in-limit samples in progress, flt_flag still high
module jug_fltcfm #(
    parameter int CFM_CNT = 8,
    parameter int RCV_CNT = 16,
    parameter int EVT_W   = 16
) (
    input logic          clk_sys,
    input logic          rst_sys,
    jug_fltcfm_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_NORMAL  = 2'd0,
        ST_SUSPECT = 2'd1,
        ST_FAULT   = 2'd2,
        ST_RECOVER = 2'd3
    } state_t;

    // Run counter compares are done one bit wider so cnt+1 can never wrap.
    localparam logic [8:0] CFM_L = 9'(CFM_CNT);
    localparam logic [8:0] RCV_L = 9'(RCV_CNT);

    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             flag_q, flag_d;
    logic             pulse_q, pulse_d;
    logic [EVT_W-1:0] evt_q, evt_d;
    logic [8:0]       cnt_inc;
    logic             confirm;

    assign cnt_inc = {1'b0, cnt_q} + 9'd1;

    // Next state, run counter, event counter and registered output values.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        evt_d   = evt_q;
        confirm = 1'b0;
        if (!bus.chn_en) begin
            // Disabled channel: idle, but keep the event history.
            state_d = ST_NORMAL;
            cnt_d   = 8'd0;
        end else begin
            if (bus.jug_vld) begin
                case (state_q)
                    ST_NORMAL: begin
                        if (bus.jug_result) begin
                            state_d = ST_SUSPECT;
                            cnt_d   = 8'd1;
                        end else begin
                            cnt_d   = 8'd0;
                        end
                    end
                    ST_SUSPECT: begin
                        if (bus.jug_result) begin
                            if (cnt_inc == CFM_L) begin
                                state_d = ST_FAULT;
                                cnt_d   = 8'd0;
                                confirm = 1'b1;
                            end else begin
                                cnt_d   = cnt_inc[7:0];
                            end
                        end else begin
                            state_d = ST_NORMAL;
                            cnt_d   = 8'd0;
                        end
                    end
                    ST_FAULT: begin
`ifdef FLT_LATCH_EN
                        if (!bus.jug_result && bus.flt_clr) begin
                            state_d = ST_NORMAL;
                            cnt_d   = 8'd0;
                        end
`else
                        if (!bus.jug_result) begin
                            state_d = ST_RECOVER;
                            cnt_d   = 8'd1;
                        end
`endif
                    end
                    ST_RECOVER: begin
                        if (!bus.jug_result) begin
                            if (cnt_inc == RCV_L) begin
                                state_d = ST_NORMAL;
                                cnt_d   = 8'd0;
                            end else begin
                                cnt_d   = cnt_inc[7:0];
                            end
                        end else begin
                            // Relapse: back to FAULT without a new confirmation.
                            state_d = ST_FAULT;
                            cnt_d   = 8'd0;
                        end
                    end
                    default: begin
                        state_d = ST_NORMAL;
                        cnt_d   = 8'd0;
                    end
                endcase
            end
            if (bus.flt_clr) begin
                evt_d = '0;
            end
            // A confirmation in the clear cycle counts after the clear.
            if (confirm) begin
                if (bus.flt_clr) begin
                    evt_d = EVT_W'(1);
                end else if (!(&evt_q)) begin
                    evt_d = evt_q + EVT_W'(1);
                end
            end
        end
        flag_d  = (state_d == ST_FAULT) || (state_d == ST_RECOVER);
        pulse_d = confirm;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_sys) begin
        if (rst_sys) begin
            state_q <= ST_NORMAL;
            cnt_q   <= 8'd0;
            flag_q  <= 1'b0;
            pulse_q <= 1'b0;
            evt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            flag_q  <= flag_d;
            pulse_q <= pulse_d;
            evt_q   <= evt_d;
        end
    end

    assign bus.flt_flag  = flag_q;
    assign bus.flt_pulse = pulse_q;
    assign bus.flt_cnt   = evt_q;
    assign bus.flt_sta   = state_q;

endmodule

// File: tb/tb_jug_fltcfm.sv
// Directed bench for jug_fltcfm: a vector table of per-cycle inputs and
// expected registered outputs, plus hand-written reset sequences.
// A 3-bit event counter is used so saturation is reachable in few cycles.
module tb_jug_fltcfm;

    localparam int EVT_W = 3;

    logic clk_sys = 1'b0;
    logic rst_sys = 1'b1;

    always #5 clk_sys = ~clk_sys;

    jug_fltcfm_if #(.EVT_W(EVT_W)) bus ();

    jug_fltcfm #(
        .CFM_CNT (8),
        .RCV_CNT (16),
        .EVT_W   (EVT_W)
    ) dut (
        .clk_sys (clk_sys),
        .rst_sys (rst_sys),
        .bus     (bus)
    );

    typedef struct {
        logic       en;
        logic       vld;
        logic       res;
        logic       clr;
        logic [1:0] sta;
        logic       flag;
        logic       pulse;
        logic [2:0] cnt;
    } vec_t;

    vec_t vq[$];
    int   total = 0;
    int   bad   = 0;

    task automatic add(input logic en, input logic vld, input logic res, input logic clr,
                       input int sta, input logic flag, input logic pulse, input int cnt);
        vec_t v;
        v.en = en; v.vld = vld; v.res = res; v.clr = clr;
        v.sta = 2'(sta); v.flag = flag; v.pulse = pulse; v.cnt = 3'(cnt);
        vq.push_back(v);
    endtask

    task automatic add_n(input int n, input logic en, input logic vld, input logic res,
                         input logic clr, input int sta, input logic flag, input logic pulse,
                         input int cnt);
        for (int i = 0; i < n; i++) add(en, vld, res, clr, sta, flag, pulse, cnt);
    endtask

    task automatic chk(input string name, input int idx, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s [%0d]: got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic en, input logic vld, input logic res, input logic clr);
        bus.chn_en     = en;
        bus.jug_vld    = vld;
        bus.jug_result = res;
        bus.flt_clr    = clr;
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk_all(input string tag, input int idx, input int sta, input int flag,
                           input int pulse, input int cnt);
        chk({tag, ".sta"},   idx, int'(bus.flt_sta),   sta);
        chk({tag, ".flag"},  idx, int'(bus.flt_flag),  flag);
        chk({tag, ".pulse"}, idx, int'(bus.flt_pulse), pulse);
        chk({tag, ".cnt"},   idx, int'(bus.flt_cnt),   cnt);
    endtask

    initial begin
        int c;
        bus.chn_en = 1'b1; bus.jug_vld = 1'b0; bus.jug_result = 1'b0; bus.flt_clr = 1'b0;

        // Glitch reject: 7 over, 1 in, 7 over, 1 in.
        add_n(7, 1, 1, 1, 0, 1, 0, 0, 0);
        add  (   1, 1, 0, 0, 0, 0, 0, 0);
        add_n(7, 1, 1, 1, 0, 1, 0, 0, 0);
        add  (   1, 1, 0, 0, 0, 0, 0, 0);
        // Confirm on the 8th over-limit sample; pulse lasts one cycle.
        add_n(7, 1, 1, 1, 0, 1, 0, 0, 0);
        add  (   1, 1, 1, 0, 2, 1, 1, 1);
        add  (   1, 0, 0, 0, 2, 1, 0, 1);
        add  (   1, 1, 1, 0, 2, 1, 0, 1);
`ifdef FLT_LATCH_EN
        // Latched fault ignores in-limit samples; only clr + valid in-limit releases.
        add_n(100, 1, 1, 0, 0, 2, 1, 0, 1);
        add  (     1, 1, 1, 1, 2, 1, 0, 0);
        add  (     1, 0, 0, 1, 2, 1, 0, 0);
        add  (     1, 1, 0, 1, 0, 0, 0, 0);
`else
        // Recovery hysteresis: 15 in, 1 over, 16 in.
        add  (    1, 1, 0, 0, 3, 1, 0, 1);
        add_n(14, 1, 1, 0, 0, 3, 1, 0, 1);
        add  (    1, 1, 1, 0, 2, 1, 0, 1);
        add_n(15, 1, 1, 0, 0, 3, 1, 0, 1);
        add  (    1, 1, 0, 0, 0, 0, 0, 1);
        add  (    1, 0, 0, 1, 0, 0, 0, 0);
`endif
        // Gaps: idle cycles (with result=1 on the wire) hold state.
        for (int i = 0; i < 7; i++) begin
            add(1, 1, 1, 0, 1, 0, 0, 0);
            add(1, 0, 1, 0, 1, 0, 0, 0);
        end
        add(1, 1, 1, 0, 2, 1, 1, 1);
        add(1, 0, 0, 0, 2, 1, 0, 1);
        // Build flt_cnt up to 3, with chn_en=0 dropping the fault each time.
        add  (   0, 1, 1, 0, 0, 0, 0, 1);
        add_n(7, 1, 1, 1, 0, 1, 0, 0, 1);
        add  (   1, 1, 1, 0, 2, 1, 1, 2);
        add  (   0, 0, 0, 0, 0, 0, 0, 2);
        add_n(7, 1, 1, 1, 0, 1, 0, 0, 2);
        add  (   1, 1, 1, 0, 2, 1, 1, 3);
        // Disable in FAULT: flag/state drop, count kept, jug_vld ignored.
        add  (   0, 1, 1, 0, 0, 0, 0, 3);
        add  (   0, 1, 1, 0, 0, 0, 0, 3);
        // Clear coinciding with a confirmation leaves flt_cnt=1.
        add_n(7, 1, 1, 1, 0, 1, 0, 0, 3);
        add  (   1, 1, 1, 1, 2, 1, 1, 1);
        // Saturation of the 3-bit counter at 7; pulse still fires.
        for (int k = 2; k <= 8; k++) begin
            c = (k > 7) ? 7 : k;
            add  (   0, 0, 0, 0, 0, 0, 0, k - 1 > 7 ? 7 : k - 1);
            add_n(7, 1, 1, 1, 0, 1, 0, 0, k - 1 > 7 ? 7 : k - 1);
            add  (   1, 1, 1, 0, 2, 1, 1, c);
        end
        add(1, 0, 0, 0, 2, 1, 0, 7);

        // Reset state.
        @(posedge clk_sys);
        @(posedge clk_sys);
        #1;
        chk_all("reset", 0, 0, 0, 0, 0);
        rst_sys = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].en, vq[i].vld, vq[i].res, vq[i].clr);
            chk_all("vec", i, int'(vq[i].sta), int'(vq[i].flag),
                    int'(vq[i].pulse), int'(vq[i].cnt));
        end

        // Reset in FAULT with the event counter saturated: everything clears.
        rst_sys = 1'b1;
        drive(1, 1, 1, 0);
        rst_sys = 1'b0;
        chk_all("rst_fault", 0, 0, 0, 0, 0);

        // Reset mid-SUSPECT must clear the run counter: 5 over, reset, then
        // a fresh run still needs all 8 samples.
        for (int i = 0; i < 5; i++) drive(1, 1, 1, 0);
        chk_all("pre_rst", 0, 1, 0, 0, 0);
        rst_sys = 1'b1;
        drive(1, 1, 1, 0);
        rst_sys = 1'b0;
        chk_all("rst_susp", 0, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) drive(1, 1, 1, 0);
        chk_all("post_rst7", 0, 1, 0, 0, 0);
        drive(1, 1, 1, 0);
        chk_all("post_rst8", 0, 2, 1, 1, 1);

        // Reset on the cycle right after a confirmation kills the pulse.
        rst_sys = 1'b1;
        drive(1, 0, 0, 0);
        rst_sys = 1'b0;
        chk_all("rst_pulse", 0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/jug_fltcfm.md
Name: jug_fltcfm

Overview:
- Fault-confirmation block that consumes the per-sample over-limit result from the AI channel electrical-limit comparator.
- It debounces that result into a confirmed channel fault flag, using separate confirm and recover sample counts (hysteresis).
- It also keeps a saturating fault-event counter.
- Sits in aichctl/faultprc between the comparator output and the channel fault reporting / status registers.

Parameters:
- CFM_CNT, 8: consecutive valid over-limit samples required to confirm a fault (legal range 2..255).
- RCV_CNT, 16: consecutive valid in-limit samples required to leave fault (legal range 2..255).
- EVT_W, 16: width of the fault-event counter.

Ports:
- clk_sys  input  1  system clock; the only clock.
- rst_sys  input  1  reset; synchronous, active-high.
- chn_en  input  1  channel enable; 0 forces the block idle.
- jug_vld  input  1  one-cycle strobe; jug_result is a new sample this cycle.
- jug_result  input  1  1 = sample over limit, 0 = within limit.
- flt_clr  input  1  one-cycle clear request for the event counter and the fault latch.
- flt_flag  output  1  confirmed fault level.
- flt_pulse  output  1  one-cycle pulse on each fault confirmation.
- flt_cnt  output  EVT_W  count of fault confirmations; saturates at all-ones.
- flt_sta  output  2  state code: 0 NORMAL, 1 SUSPECT, 2 FAULT, 3 RECOVER.

Behaviour:
- Timing and control:
  - All logic is synchronous to clk_sys. rst_sys is synchronous and active-high.
  - Reset values: flt_flag=0, flt_pulse=0, flt_cnt=0, flt_sta=0 (NORMAL), internal run counter cnt=0.
  - Priority order: rst_sys > chn_en=0 > state machine / flt_clr.
  - Only cycles with jug_vld=1 advance the state machine. Cycles with jug_vld=0 hold state and cnt.
  - cnt is 8 bits and never exceeds max(CFM_CNT, RCV_CNT).
- State machine (jug_vld=1 assumed unless stated):
  - NORMAL:
    - result=1: go to SUSPECT, cnt=1.
    - result=0: stay, cnt=0.
  - SUSPECT:
    - result=1 and cnt+1<CFM_CNT: cnt+1.
    - result=1 and cnt+1==CFM_CNT: go to FAULT, cnt=0, flt_flag=1, flt_pulse=1 for one cycle, flt_cnt+1 (saturating).
    - result=0: go to NORMAL, cnt=0.
  - FAULT:
    - result=0: go to RECOVER, cnt=1.
    - result=1: stay.
  - RECOVER:
    - result=0 and cnt+1<RCV_CNT: cnt+1.
    - result=0 and cnt+1==RCV_CNT: go to NORMAL, cnt=0, flt_flag=0.
    - result=1: go back to FAULT, cnt=0. This is not a new confirmation: no flt_pulse, no flt_cnt increment.
- Outputs:
  - All outputs are registered.
  - flt_flag changes on the same clock edge that flt_sta enters or leaves the fault region. The fault region is FAULT and RECOVER.
  - flt_flag=1 in both FAULT and RECOVER.
  - Latency: the pulse appears 1 clk after the confirming sample's jug_vld cycle.
- chn_en=0:
  - Next edge: flt_sta=NORMAL, cnt=0, flt_flag=0, flt_pulse=0.
  - flt_cnt is retained. jug_vld is ignored.
- flt_clr:
  - Sets flt_cnt to 0 on the next edge.
  - If a confirmation happens in the same cycle, flt_cnt=1 (the confirmation counts after the clear).
  - Outside latch mode, flt_clr does not affect state or flt_flag.
- Saturation: flt_cnt at all-ones stays at all-ones on further confirmations. flt_pulse still fires.
- Reset mid-operation: any state returns to NORMAL with all outputs at their reset values.

Optional Feature:
- Macro: FLT_LATCH_EN.
- Defined:
  - FAULT never moves to RECOVER on in-limit samples. flt_flag stays at 1.
  - A fault is released only by flt_clr=1 in FAULT while the current cycle has jug_vld=1 and jug_result=0. Next edge: NORMAL, flt_flag=0, cnt=0.
  - flt_clr with jug_result=1, or without jug_vld, only clears flt_cnt.
  - RECOVER (code 3) is unreachable.
- Undefined: auto-recovery via RECOVER as described above.

Test Plan:
- Confirm: CFM_CNT=8. Eight consecutive jug_vld pulses with result=1 -> flt_sta 1 after the 1st, flt_flag=1 and one flt_pulse after the 8th, flt_cnt=1.
- Glitch reject: 7 over-limit samples, 1 in-limit, 7 over-limit -> flt_flag stays 0, flt_cnt=0, flt_sta returns to 0 after the in-limit sample.
- Recovery hysteresis: from FAULT, 15 in-limit samples, 1 over-limit, 16 in-limit -> flt_flag stays 1 until the 16th of the final run; no second flt_pulse; flt_cnt unchanged.
- Gaps: the over-limit run is interleaved with idle cycles (jug_vld=0) -> same confirmation point as the contiguous run; state holds during gaps.
- Priority: chn_en=0 while in FAULT with flt_cnt=3 -> next edge flt_flag=0, flt_sta=0, flt_cnt=3. A later flt_clr coinciding with a confirmation -> flt_cnt=1.
- Latch (FLT_LATCH_EN): 100 in-limit samples after fault -> flt_flag=1. flt_clr with an in-limit sample -> flt_flag=0, flt_sta=0.
